// File: rtl/mpt_mem_arbiter.sv
`default_nettype none
// ============================================================================
// mpt_mem_arbiter: two-to-one MEM arbiter (load/store walkers to one dcache
// port), one outstanding transaction. Macro MPT_ARB_ROUND_ROBIN_EN selects
// round-robin arbitration; default is fixed load-over-store priority.
// Revision: 1.0
// ============================================================================
module mpt_mem_arbiter #(
  parameter int DATA_WIDTH = 64,
  parameter int ADDR_WIDTH = 64
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  // load walker slave port
  input  logic                    s_load_mem_req,
  output logic                    s_load_mem_gnt,
  output logic                    s_load_mem_valid,
  input  logic [ADDR_WIDTH-1:0]   s_load_mem_addr,
  output logic [DATA_WIDTH-1:0]   s_load_mem_rdata,
  input  logic [DATA_WIDTH-1:0]   s_load_mem_wdata,
  input  logic                    s_load_mem_we,
  input  logic [DATA_WIDTH/8-1:0] s_load_mem_be,
  output logic                    s_load_mem_error,
  // store walker slave port
  input  logic                    s_store_mem_req,
  output logic                    s_store_mem_gnt,
  output logic                    s_store_mem_valid,
  input  logic [ADDR_WIDTH-1:0]   s_store_mem_addr,
  output logic [DATA_WIDTH-1:0]   s_store_mem_rdata,
  input  logic [DATA_WIDTH-1:0]   s_store_mem_wdata,
  input  logic                    s_store_mem_we,
  input  logic [DATA_WIDTH/8-1:0] s_store_mem_be,
  output logic                    s_store_mem_error,
  // master port towards the dcache protocol converter
  output logic                    m_mem_req,
  input  logic                    m_mem_gnt,
  input  logic                    m_mem_valid,
  output logic [ADDR_WIDTH-1:0]   m_mem_addr,
  input  logic [DATA_WIDTH-1:0]   m_mem_rdata,
  output logic [DATA_WIDTH-1:0]   m_mem_wdata,
  output logic                    m_mem_we,
  output logic [DATA_WIDTH/8-1:0] m_mem_be,
  input  logic                    m_mem_error,
  // status
  output logic                    busy_o,
  output logic                    owner_o
);

  localparam logic [0:0] ST_IDLE     = 1'b0;
  localparam logic [0:0] ST_WAIT_RSP = 1'b1;

  logic [0:0] r_state;
  logic [0:0] w_state_next;
  logic       r_owner;
  logic       w_sel_store;
  logic       w_handshake;
  logic       w_idle;

  assign w_idle      = (r_state == ST_IDLE);
  assign w_handshake = m_mem_req && m_mem_gnt;

`ifdef MPT_ARB_ROUND_ROBIN_EN
  // 1: store wins the next contention; flips only on an accepted handshake
  logic r_prio_store;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_prio_store <= 1'b0;
    end else if (w_handshake) begin
      r_prio_store <= ~w_sel_store;
    end
  end

  assign w_sel_store = s_store_mem_req && (!s_load_mem_req || r_prio_store);
`else
  assign w_sel_store = s_store_mem_req && !s_load_mem_req;
`endif

  // State register
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_state <= ST_IDLE;
      r_owner <= 1'b0;
    end else begin
      r_state <= w_state_next;
      if (w_handshake) begin
        r_owner <= w_sel_store;
      end
    end
  end

  // Next-state logic
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE:     if (w_handshake) w_state_next = ST_WAIT_RSP;
      ST_WAIT_RSP: if (m_mem_valid) w_state_next = ST_IDLE;
      default:     w_state_next = ST_IDLE;
    endcase
  end

  // Output logic: request mux in IDLE, response demux in WAIT_RSP
  always_comb begin
    m_mem_req         = w_idle && (s_load_mem_req || s_store_mem_req);
    m_mem_addr        = w_sel_store ? s_store_mem_addr  : s_load_mem_addr;
    m_mem_wdata       = w_sel_store ? s_store_mem_wdata : s_load_mem_wdata;
    m_mem_we          = w_sel_store ? s_store_mem_we    : s_load_mem_we;
    m_mem_be          = w_sel_store ? s_store_mem_be    : s_load_mem_be;
    s_load_mem_gnt    = w_idle && !w_sel_store && s_load_mem_req && m_mem_gnt;
    s_store_mem_gnt   = w_idle && w_sel_store && m_mem_gnt;
    s_load_mem_valid  = !w_idle && !r_owner && m_mem_valid;
    s_store_mem_valid = !w_idle && r_owner && m_mem_valid;
    s_load_mem_error  = !w_idle && !r_owner && m_mem_valid && m_mem_error;
    s_store_mem_error = !w_idle && r_owner && m_mem_valid && m_mem_error;
    s_load_mem_rdata  = m_mem_rdata;
    s_store_mem_rdata = m_mem_rdata;
    busy_o            = !w_idle;
    owner_o           = r_owner;
  end

endmodule
`default_nettype wire

// File: tb/tb_mpt_mem_arbiter.sv
`default_nettype none
// ============================================================================
// tb_mpt_mem_arbiter: directed vector table, corner-case sequences and a
// randomized run against a transaction-level reference model.
// Revision: 1.0
// ============================================================================
module tb_mpt_mem_arbiter;
  localparam int DW = 64;
  localparam int AW = 64;
  localparam int BW = DW / 8;
`ifdef MPT_ARB_ROUND_ROBIN_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n;
  logic          l_req, l_gnt, l_valid, l_we, l_err;
  logic [AW-1:0] l_addr;
  logic [DW-1:0] l_rdata, l_wdata;
  logic [BW-1:0] l_be;
  logic          s_req, s_gnt, s_valid, s_we, s_err;
  logic [AW-1:0] s_addr;
  logic [DW-1:0] s_rdata, s_wdata;
  logic [BW-1:0] s_be;
  logic          m_req, m_gnt, m_valid, m_we, m_err;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_rdata, m_wdata;
  logic [BW-1:0] m_be;
  logic          busy, owner;

  int pass_cnt  = 0;
  int total_cnt = 0;

  always #5 clk = ~clk;

  mpt_mem_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .s_load_mem_req(l_req), .s_load_mem_gnt(l_gnt), .s_load_mem_valid(l_valid),
    .s_load_mem_addr(l_addr), .s_load_mem_rdata(l_rdata), .s_load_mem_wdata(l_wdata),
    .s_load_mem_we(l_we), .s_load_mem_be(l_be), .s_load_mem_error(l_err),
    .s_store_mem_req(s_req), .s_store_mem_gnt(s_gnt), .s_store_mem_valid(s_valid),
    .s_store_mem_addr(s_addr), .s_store_mem_rdata(s_rdata), .s_store_mem_wdata(s_wdata),
    .s_store_mem_we(s_we), .s_store_mem_be(s_be), .s_store_mem_error(s_err),
    .m_mem_req(m_req), .m_mem_gnt(m_gnt), .m_mem_valid(m_valid), .m_mem_addr(m_addr),
    .m_mem_rdata(m_rdata), .m_mem_wdata(m_wdata), .m_mem_we(m_we), .m_mem_be(m_be),
    .m_mem_error(m_err),
    .busy_o(busy), .owner_o(owner)
  );

  typedef struct {
    logic       rst_n, lreq, sreq, gnt, valid, err;
    logic [8:0] exp; // {m_req, l_gnt, s_gnt, l_valid, s_valid, l_err, s_err, busy, owner}
  } vec_t;

  vec_t tbl[19];

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  task automatic drive(input logic r, input logic lq, input logic sq,
                       input logic g, input logic v, input logic e);
    rst_n = r; l_req = lq; s_req = sq; m_gnt = g; m_valid = v; m_err = e;
  endtask

  function automatic logic [8:0] ctrl();
    return {m_req, l_gnt, s_gnt, l_valid, s_valid, l_err, s_err, busy, owner};
  endfunction

  task automatic do_reset();
    @(negedge clk);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  // Transaction-level reference: busy flag, owner, and who won the last grant
  bit mdl_busy, mdl_owner, mdl_last;

  task automatic model_reset();
    mdl_busy = 0; mdl_owner = 0; mdl_last = 1; // last=store => load has priority
  endtask

  initial begin
    logic [3:0] grants;
    int         n_grants;
    int         since;
    bit         win;
    logic [8:0] e;

    tbl[0]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 9'b000000000};
    tbl[1]  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 9'b110000000};
    tbl[2]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 9'b000000010};
    tbl[3]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 9'b000000010};
    tbl[4]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 9'b000100010};
    tbl[5]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 9'b000000000};
    tbl[6]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 9'b000000000};
    tbl[7]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 9'b000000000};
    tbl[8]  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 9'b110000000};
    tbl[9]  = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 9'b000000010};
    tbl[10] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 9'b000100010};
    tbl[11] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 9'b101000000};
    tbl[12] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 9'b000000011};
    tbl[13] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 9'b000010111};
    tbl[14] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 9'b000000001};
    tbl[15] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 9'b110000001};
    tbl[16] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 9'b000000010};
    tbl[17] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 9'b000000000};
    tbl[18] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 9'b000000000};

    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    l_addr = 64'h8000_0040; l_wdata = '0; l_we = 1'b0; l_be = 8'h00;
    s_addr = 64'h0000_1000; s_wdata = '0; s_we = 1'b1; s_be = 8'h0F;
    m_rdata = 64'hDEAD_BEEF_0000_0001;
    repeat (2) @(posedge clk);

    // Directed table: reset, load read, spurious valid, blocked store, mid-transaction reset
    for (int i = 0; i < 19; i++) begin
      @(negedge clk);
      drive(tbl[i].rst_n, tbl[i].lreq, tbl[i].sreq, tbl[i].gnt, tbl[i].valid, tbl[i].err);
      #1;
      chk($sformatf("vec%0d_ctrl", i), 256'(ctrl()), 256'(tbl[i].exp));
      if (tbl[i].exp[8])
        chk($sformatf("vec%0d_addr", i), 256'(m_addr), 256'(tbl[i].exp[6] ? s_addr : l_addr));
      if (tbl[i].exp[5])
        chk($sformatf("vec%0d_rdata", i), 256'(l_rdata), 256'(64'hDEAD_BEEF_0000_0001));
    end

    // Store write with error response
    do_reset();
    @(negedge clk);
    s_wdata = 64'h0123_4567_89AB_CDEF; s_be = 8'hFF; s_we = 1'b1; s_addr = 64'h0000_2000;
    drive(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    #1;
    chk("wr_req", 256'({m_req, s_gnt, l_gnt, m_we, m_be}), 256'({3'b110, 1'b1, 8'hFF}));
    chk("wr_wdata", 256'(m_wdata), 256'(64'h0123_4567_89AB_CDEF));
    chk("wr_addr", 256'(m_addr), 256'(64'h0000_2000));
    @(negedge clk);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    #1;
    chk("wr_rsp", 256'({s_valid, s_err, l_valid, l_err}), 256'(4'b1100));

    // Continuous contention, response two cycles after each grant
    do_reset();
    grants = '0; n_grants = 0; since = 5;
    for (int c = 0; c < 16; c++) begin
      @(negedge clk);
      drive(1'b1, 1'b1, 1'b1, 1'b1, since == 2, 1'b0);
      #1;
      if (l_gnt || s_gnt) begin
        if (n_grants < 4) grants[n_grants] = s_gnt;
        n_grants++;
        since = 0;
      end else begin
        since++;
      end
    end
    chk("contend_count", 256'(n_grants >= 4), 256'(1));
    chk("contend_order", 256'(grants), 256'(RR ? 4'b1010 : 4'b0000));

    // Randomized run against the reference model
    do_reset();
    model_reset();
    for (int c = 0; c < 3000; c++) begin
      logic r, lq, sq, g, v, er;
      @(negedge clk);
      r  = ($urandom_range(0, 40) != 0);
      lq = ($urandom_range(0, 9) < 6);
      sq = ($urandom_range(0, 9) < 6);
      g  = ($urandom_range(0, 9) < 7);
      v  = ($urandom_range(0, 9) < 3);
      er = $urandom_range(0, 1);
      l_addr = {$urandom, $urandom}; s_addr = {$urandom, $urandom};
      l_wdata = {$urandom, $urandom}; s_wdata = {$urandom, $urandom};
      l_we = $urandom_range(0, 1); s_we = $urandom_range(0, 1);
      l_be = 8'($urandom); s_be = 8'($urandom);
      m_rdata = {$urandom, $urandom};
      drive(r, lq, sq, g, v, er);
      #1;
      win = (lq && sq) ? (RR ? !mdl_last : 1'b0) : sq;
      e[8] = !mdl_busy && (lq || sq);
      e[7] = e[8] && !win && g;
      e[6] = e[8] && win && g;
      e[5] = mdl_busy && !mdl_owner && v;
      e[4] = mdl_busy && mdl_owner && v;
      e[3] = e[5] && er;
      e[2] = e[4] && er;
      e[1] = mdl_busy;
      e[0] = mdl_owner;
      chk($sformatf("rand%0d_ctrl", c), 256'(ctrl()), 256'(e));
      chk($sformatf("rand%0d_rdata", c), 256'({l_rdata, s_rdata}), 256'({m_rdata, m_rdata}));
      if (e[8])
        chk($sformatf("rand%0d_req", c), 256'({m_addr, m_wdata, m_we, m_be}),
            win ? 256'({s_addr, s_wdata, s_we, s_be}) : 256'({l_addr, l_wdata, l_we, l_be}));
      if (!r) begin
        model_reset();
      end else if (e[8] && g) begin
        mdl_busy = 1; mdl_owner = win; mdl_last = win;
      end else if (mdl_busy && v) begin
        mdl_busy = 0;
      end
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
`default_nettype wire
